// File: rtl/mode_counter.sv
// rtl/mode_counter.sv - up/down counter with step, limit, wrap/saturate/one-shot modes and enable prescaler
module mode_counter #(
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ld,
  input  logic [WIDTH-1:0]      v,
  input  logic                  inc,
  input  logic                  dir,
  input  logic [WIDTH-1:0]      step,
  input  logic [WIDTH-1:0]      limit,
  input  logic [1:0]            mode,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic [WIDTH-1:0]      count,
  output logic                  tc,
  output logic                  done
);

  localparam logic [1:0] MODE_SAT     = 2'b01;
  localparam logic [1:0] MODE_ONESHOT = 2'b10;

  logic [PRESCALE_W-1:0] pre_cnt;
  logic                  tick;
  logic [WIDTH:0]        sum;
  logic [WIDTH-1:0]      diff;
  logic                  up_over;
  logic                  dn_under;
  logic                  boundary;
  logic                  clamp;
  logic [WIDTH-1:0]      next_count;

  always_comb begin
    tick       = inc & (pre_cnt >= prescale) & ~done;
    sum        = {1'b0, count} + {1'b0, step};
    diff       = count - step;
    up_over    = sum > {1'b0, limit};
    dn_under   = step > count;
    // A zero step never moves the count, so it can never cross a boundary.
    boundary   = (step != '0) & (dir ? up_over : dn_under);
    clamp      = (mode == MODE_SAT) || (mode == MODE_ONESHOT);
    next_count = dir ? sum[WIDTH-1:0] : diff;
    if (boundary) begin
      if (clamp) next_count = dir ? limit : '0;
      else       next_count = dir ? '0 : limit;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count   <= '0;
      tc      <= 1'b0;
      done    <= 1'b0;
      pre_cnt <= '0;
    end else if (ld) begin
      count   <= v;
      tc      <= 1'b0;
      done    <= 1'b0;
      pre_cnt <= '0;
    end else if (tick) begin
      count   <= next_count;
      tc      <= boundary;
      pre_cnt <= '0;
      if (boundary && (mode == MODE_ONESHOT)) done <= 1'b1;
    end else begin
      tc <= 1'b0;
      if (inc && !done) pre_cnt <= pre_cnt + PRESCALE_W'(1);
    end
  end

endmodule

// File: tb/tb_mode_counter.sv
// tb/tb_mode_counter.sv - directed self-checking bench for mode_counter
module tb_mode_counter;

  logic        clk = 1'b0;
  logic        rst, ld, inc, dir;
  logic [7:0]  v, step, limit;
  logic [1:0]  mode;
  logic [15:0] prescale;
  logic [7:0]  count;
  logic        tc, done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mode_counter #(.WIDTH(8), .PRESCALE_W(16)) dut (
    .clk(clk), .rst(rst), .ld(ld), .v(v), .inc(inc), .dir(dir),
    .step(step), .limit(limit), .mode(mode), .prescale(prescale),
    .count(count), .tc(tc), .done(done)
  );

  // Advance one edge, then sample 1 time unit later; inputs change right after.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1; ld = 1; v = 8'd55; inc = 1; dir = 1; step = 8'd1; limit = 8'd255;
    mode = 2'b00; prescale = 16'd0;
    cyc();
    cyc();
    checks++;
    if (count !== 8'd0 || tc !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset: count=%0d tc=%b done=%b, expected 0 0 0", count, tc, done);
    end
    rst = 0; ld = 0;
    for (int i = 1; i <= 5; i++) begin
      cyc();
      checks++;
      if (count !== 8'(i) || tc !== 1'b0) begin
        errors++;
        $display("FAIL basic_up[%0d]: count=%0d tc=%b, expected %0d 0", i, count, tc, i);
      end
    end
  endtask

  task automatic test_wrap();
    logic [7:0] ec [0:6] = '{8'd250, 8'd253, 8'd0, 8'd3, 8'd1, 8'd100, 8'd98};
    logic       et [0:6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    inc = 1; mode = 2'b00; prescale = 16'd0;
    for (int i = 0; i < 7; i++) begin
      ld = (i == 0) || (i == 4);
      if (i == 0) begin v = 8'd250; limit = 8'd255; step = 8'd3; dir = 1; end
      if (i == 4) begin v = 8'd1; limit = 8'd100; step = 8'd2; dir = 0; end
      cyc();
      checks++;
      if (count !== ec[i] || tc !== et[i]) begin
        errors++;
        $display("FAIL wrap[%0d]: count=%0d tc=%b, expected %0d %b", i, count, tc, ec[i], et[i]);
      end
    end
    ld = 0;
  endtask

  task automatic test_saturate();
    logic [7:0] ec [0:7] = '{8'd8, 8'd10, 8'd10, 8'd10, 8'd6, 8'd2, 8'd0, 8'd0};
    logic       et [0:7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    inc = 1; mode = 2'b01; prescale = 16'd0; limit = 8'd10; step = 8'd4;
    for (int i = 0; i < 8; i++) begin
      ld  = (i == 0);
      v   = 8'd8;
      dir = (i < 4);
      cyc();
      checks++;
      if (count !== ec[i] || tc !== et[i]) begin
        errors++;
        $display("FAIL saturate[%0d]: count=%0d tc=%b, expected %0d %b", i, count, tc, ec[i], et[i]);
      end
    end
    ld = 0;
  endtask

  task automatic test_oneshot();
    logic [7:0] ec [0:7] = '{8'd0, 8'd2, 8'd4, 8'd5, 8'd5, 8'd5, 8'd1, 8'd3};
    logic       et [0:7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic       ed [0:7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    inc = 1; mode = 2'b10; prescale = 16'd0; limit = 8'd5; step = 8'd2; dir = 1;
    for (int i = 0; i < 8; i++) begin
      ld = (i == 0) || (i == 6);
      v  = (i == 0) ? 8'd0 : 8'd1;
      cyc();
      checks++;
      if (count !== ec[i] || tc !== et[i] || done !== ed[i]) begin
        errors++;
        $display("FAIL oneshot[%0d]: count=%0d tc=%b done=%b, expected %0d %b %b",
                 i, count, tc, done, ec[i], et[i], ed[i]);
      end
    end
    ld = 0;
  endtask

  task automatic test_prescaler();
    // Cycle 0 loads 0; inc drops on cycles 11-12; prescale drops to 0 on cycle 17 (pre_cnt=2).
    logic [7:0] ec [0:18] = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd1, 8'd1, 8'd1, 8'd2,
                              8'd2, 8'd2, 8'd2, 8'd2, 8'd2, 8'd3, 8'd3, 8'd3, 8'd4, 8'd5};
    mode = 2'b00; limit = 8'd255; step = 8'd1; dir = 1; v = 8'd0;
    for (int i = 0; i < 19; i++) begin
      ld       = (i == 0);
      inc      = !(i == 11 || i == 12);
      prescale = (i >= 17) ? 16'd0 : 16'd3;
      cyc();
      checks++;
      if (count !== ec[i] || tc !== 1'b0) begin
        errors++;
        $display("FAIL prescale[%0d]: count=%0d tc=%b, expected %0d 0", i, count, tc, ec[i]);
      end
    end
    inc = 1; prescale = 16'd0;
  endtask

  task automatic test_priority();
    logic [7:0] ec [0:8] = '{8'd9, 8'd0, 8'd9, 8'd7, 8'd10, 8'd0, 8'd0, 8'd20, 8'd20};
    logic       et [0:8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic       ed [0:8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    inc = 1; prescale = 16'd0; dir = 1; step = 8'd4; limit = 8'd10; mode = 2'b10;
    for (int i = 0; i < 9; i++) begin
      rst = (i == 1);
      ld  = (i <= 3) || (i == 5) || (i == 7);
      case (i)
        0, 2:    v = 8'd9;
        1, 3:    v = 8'd7;
        default: v = (i == 7) ? 8'd20 : 8'd0;
      endcase
      if (i == 5) begin limit = 8'd0; step = 8'd1; mode = 2'b00; end
      if (i == 7) begin limit = 8'd10; step = 8'd0; end
      cyc();
      checks++;
      if (count !== ec[i] || tc !== et[i] || done !== ed[i]) begin
        errors++;
        $display("FAIL priority[%0d]: count=%0d tc=%b done=%b, expected %0d %b %b",
                 i, count, tc, done, ec[i], et[i], ed[i]);
      end
    end
    rst = 0; ld = 0;
  endtask

  initial begin
    test_reset();
    test_wrap();
    test_saturate();
    test_oneshot();
    test_prescaler();
    test_priority();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mode_counter.md
Name: mode_counter

Overview:
- Parametrised successor to the team's load/increment counter.
- Adds up/down direction, programmable step, a programmable upper limit, and three boundary modes: wrap, saturate and one-shot.
- Adds an enable prescaler, a terminal-count pulse and a sticky done flag.
- Used as the general-purpose timing and event counter in the lab datapath; drives display and sequencing logic.

Parameters:
- WIDTH, 8, width of count, v, step and limit.
- PRESCALE_W, 16, width of the prescaler compare value and its internal counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- ld  in  1  load count from v.
- v  in  WIDTH  preload value.
- inc  in  1  count enable; feeds the prescaler.
- dir  in  1  direction: 1 = up, 0 = down.
- step  in  WIDTH  amount added or subtracted per tick.
- limit  in  WIDTH  upper bound of the count range 0..limit.
- mode  in  2  boundary mode: 00 wrap, 01 saturate, 10 one-shot, 11 treated as wrap.
- prescale  in  PRESCALE_W  a tick occurs every prescale+1 enabled cycles.
- count  out  WIDTH  current count, registered.
- tc  out  1  terminal-count pulse, registered, one cycle wide.
- done  out  1  sticky one-shot completion flag, registered.

Behaviour:

Reset:
- On rst=1 at a clock edge: count=0, tc=0, done=0, internal pre_cnt=0.
- Priority is rst > ld > tick.

Load:
- ld=1 (no rst): count<=v, pre_cnt<=0, done<=0, tc<=0.
- inc is ignored in a load cycle.
- v > limit is legal; the next up tick treats it as an overflow.

Prescaler:
- tick = inc & (pre_cnt >= prescale) & ~done.
- The >= compare means that lowering prescale mid-count fires on the next enabled cycle.
- On a tick, pre_cnt<=0. On inc without a tick, pre_cnt<=pre_cnt+1.
- With inc=0, pre_cnt holds.
- prescale=0 gives one tick per inc cycle, equivalent to the previous block's inc behaviour.

Arithmetic:
- Computed in WIDTH+1 bits; no silent truncation.
- Up overflow: count+step > limit.
- Down underflow: step > count.
- A tick with no overflow or underflow: count<=count±step, tc<=0.
- step=0: count holds and no boundary event ever occurs.

Boundary event on a tick:
- tc<=1 for exactly one cycle; it is visible in the same cycle as the updated count.
- wrap: up gives count<=0; down gives count<=limit.
- saturate: up gives count<=limit; down gives count<=0. tc pulses on every tick that overflows, including while already saturated.
- one-shot: clamps as in saturate, and done<=1.
- While done=1, ticks are suppressed: count holds, pre_cnt holds, and tc stays 0.
- done clears only on ld or rst.

Other rules:
- tc is 0 in every cycle that does not follow a boundary-event tick.
- limit=0: range {0}. Any up tick with step≥1 is an overflow and gives count 0 (or limit=0), tc=1.
- dir, step, limit and mode may change on any cycle. They are sampled only on the tick cycle; there is no internal latching.
- Reset mid-operation wins over a simultaneous ld or tick.
- ld in the same cycle as a would-be boundary tick: the load wins, and no tc or done results.

Test Plan:
- Reset and basic up count: rst 2 cycles, then WIDTH=8, limit=255, step=1, dir=1, mode=00, prescale=0, inc=1 for 5 cycles -> count 0,1,2,3,4,5; tc=0 throughout.
- Wrap and tc: ld v=250, limit=255, step=3, up, mode=00 -> count 253, then 0 with tc=1 for that single cycle, then 3 with tc=0. Down from v=1, step=2, limit=100 -> count 100, tc=1.
- Saturate: v=8, limit=10, step=4, up, mode=01 -> 10 (tc=1), 10 (tc=1), 10 (tc=1). Switch dir=0 -> 6, 2, 0 (tc=1).
- One-shot and done: v=0, limit=5, step=2, up, mode=10 -> 2, 4, 5 with tc=1 and done=1. Further inc -> count stays 5, tc=0. ld v=1 -> done=0 and counting resumes.
- Prescaler: prescale=3, step=1, inc=1 -> count increments every 4th cycle. Drop inc for 2 cycles mid-period -> period stretches by 2. Change prescale 3→0 with pre_cnt=2 -> tick on the next enabled cycle.
- Priority: assert rst and ld together -> count=0. Assert ld with v=7 on a cycle where the tick would overflow -> count=7, tc=0, done=0.
